// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the 8-bit accumulator datapath.
// Control lines are decoded combinationally from the state register.
module control_unit #(
  parameter bit ENTER_SYNC = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic [1:0] Asel,
  output logic       Halt,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_START  = 4'b0000,
    S_FETCH  = 4'b0001,
    S_DECODE = 4'b0010,
    S_LOAD   = 4'b1000,
    S_STORE  = 4'b1001,
    S_ADD    = 4'b1010,
    S_SUB    = 4'b1011,
    S_INPUT  = 4'b1100,
    S_JZ     = 4'b1101,
    S_JPOS   = 4'b1110,
    S_HALT   = 4'b1111
  } state_t;

  typedef struct packed {
    logic       irload;
    logic       jmpmux;
    logic       pcload;
    logic       meminst;
    logic       memwr;
    logic       aload;
    logic       sub;
    logic [1:0] asel;
    logic       halt;
  } ctrl_t;

  state_t st, nxt;
  ctrl_t  ctl;
  logic   enter_evt;

  // One event per rising edge of Enter, two clocks after it reaches the pin.
  generate
    if (ENTER_SYNC) begin : g_sync
      logic [2:0] sync_pipe;
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[1:0], Enter};
      end
      assign enter_evt = sync_pipe[1] & ~sync_pipe[2];
    end else begin : g_nosync
      assign enter_evt = Enter;
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) st <= S_START;
    else       st <= nxt;
  end

  always_comb begin
    nxt = S_START;
    ctl = '0;
    case (st)
      S_START:  nxt = S_FETCH;
      S_FETCH: begin
        ctl.irload = 1'b1;
        ctl.pcload = 1'b1;
        nxt        = S_DECODE;
      end
      S_DECODE: begin
        ctl.meminst = 1'b1;
        case (IR)
          3'b000:  nxt = S_LOAD;
          3'b001:  nxt = S_STORE;
          3'b010:  nxt = S_ADD;
          3'b011:  nxt = S_SUB;
          3'b100:  nxt = S_INPUT;
          3'b101:  nxt = S_JZ;
          3'b110:  nxt = S_JPOS;
          default: nxt = S_HALT;
        endcase
      end
      S_LOAD: begin
        ctl.aload = 1'b1;
        ctl.asel  = 2'b10;
      end
      S_STORE: begin
        ctl.meminst = 1'b1;
        ctl.memwr   = 1'b1;
      end
      S_ADD:    ctl.aload = 1'b1;
      S_SUB: begin
        ctl.aload = 1'b1;
        ctl.sub   = 1'b1;
      end
      S_INPUT: begin
        ctl.asel  = 2'b01;
        ctl.aload = enter_evt;
        nxt       = enter_evt ? S_START : S_INPUT;
      end
      // Flags only gate the PC load; they never steer the next state.
      S_JZ: begin
        ctl.jmpmux = 1'b1;
        ctl.pcload = Aeq0;
      end
      S_JPOS: begin
        ctl.jmpmux = 1'b1;
        ctl.pcload = Apos;
      end
      S_HALT: begin
        ctl.halt = 1'b1;
        nxt      = S_HALT;
      end
      default:  nxt = S_START;
    endcase
  end

  assign IRload  = ctl.irload;
  assign JMPmux  = ctl.jmpmux;
  assign PCload  = ctl.pcload;
  assign Meminst = ctl.meminst;
  assign MemWr   = ctl.memwr;
  assign Aload   = ctl.aload;
  assign Sub     = ctl.sub;
  assign Asel    = ctl.asel;
  assign Halt    = ctl.halt;
  assign State   = st;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction-sequencing FSM that drives the 8-bit accumulator Datapath. It consumes IR[7:5], Aeq0 and Apos from the Datapath, plus an operator Enter key.
- It produces every Datapath control line each cycle: IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub and Asel.
- It also exports Halt and the current state for debug display.

Parameters:
- ENTER_SYNC, 1, 1 = pass Enter through a 2-flop synchronizer and rising-edge detector, so one press gives one load; 0 = Enter used directly as a level.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-high; forces state to START
- IR  input  3  opcode bits IR[7:5] from the Datapath instruction register
- Aeq0  input  1  accumulator == 0 flag from the Datapath
- Apos  input  1  accumulator > 0 flag from the Datapath
- Enter  input  1  operator input-ready key
- IRload  output  1  load instruction register
- JMPmux  output  1  1 = PC source is IR[4:0]; 0 = PC+1
- PCload  output  1  load PC
- Meminst  output  1  1 = memory address from IR[4:0]; 0 = from PC
- MemWr  output  1  memory write enable
- Aload  output  1  load accumulator
- Sub  output  1  ALU subtract select
- Asel  output  2  accumulator source: 00 = ALU, 01 = Input, 10 = memory
- Halt  output  1  high while in the HALT state
- State  output  4  current state encoding

Behaviour:
- State register: 4 bits. Reset is asynchronous; Reset=1 forces START immediately and holds it until release, including mid-instruction or from HALT.
- State encodings:
  - START=0000, FETCH=0001, DECODE=0010
  - LOAD=1000, STORE=1001, ADD=1010, SUB=1011
  - INPUT=1100, JZ=1101, JPOS=1110, HALT=1111
- Unused encodings go to START on the next clock.
- Outputs are combinational from State, plus Aeq0/Apos/Enter where noted. Any signal not listed for a state is 0. Asel defaults to 00.
  - START: all 0.
  - FETCH: IRload=1, PCload=1.
  - DECODE: Meminst=1.
  - LOAD: Aload=1, Asel=10.
  - STORE: Meminst=1, MemWr=1.
  - ADD: Aload=1, Asel=00, Sub=0.
  - SUB: Aload=1, Asel=00, Sub=1.
  - INPUT: Asel=01, Aload=enter_evt.
  - JZ: JMPmux=1, PCload=Aeq0.
  - JPOS: JMPmux=1, PCload=Apos.
  - HALT: Halt=1, all else 0.
- Transitions:
  - START -> FETCH -> DECODE.
  - DECODE -> execute state by IR: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
  - LOAD, STORE, ADD, SUB, JZ, JPOS -> START.
  - INPUT stays in INPUT while enter_evt=0; when enter_evt=1 -> START.
  - HALT -> HALT until Reset.
- Latency: a non-INPUT instruction takes exactly 4 clocks (START, FETCH, DECODE, execute). Halt asserts 3 clocks after START.
- enter_evt:
  - ENTER_SYNC=0: enter_evt = Enter.
  - ENTER_SYNC=1: enter_evt = s1 & ~s2, where s0/s1/s2 is a 3-flop shift of Enter, all reset to 0. One event per 0->1 edge; the event appears 2 clocks after the rising edge at the input.
  - Held Enter gives exactly one event.
  - An edge arriving while not in INPUT is lost. Enter must be pressed after INPUT is entered.
- Branch flags are sampled combinationally in the JZ/JPOS cycle, so the PC loads on that cycle's rising edge. Flags never alter the next state.
- Reset values: State=0000, Halt=0, all control outputs 0, sync flops 0.

Test Plan:
- Reset then IR=000 -> State sequence 0,1,2,8,0 on successive clocks. IRload=PCload=1 in FETCH only; Meminst=1 in DECODE; Aload=1 with Asel=10 in LOAD.
- IR=001 then IR=011 -> STORE cycle: Meminst=1, MemWr=1, Aload=0. SUB cycle: Aload=1, Sub=1, Asel=00. Both return to START after 1 clock.
- IR=100, ENTER_SYNC=1:
  - Enter held low 5 cycles -> State stays 1100, Aload=0.
  - Enter raised and held 10 cycles -> Aload=1 for exactly one cycle, 2 clocks after the edge, then State=0000.
- IR=101 with Aeq0=1 -> JMPmux=1, PCload=1. Repeat with Aeq0=0 -> PCload=0. IR=110 with Apos=1/0 -> PCload=1/0. All four cases return to START.
- IR=111 -> State=1111, Halt=1, held 20 cycles with any Enter/flags. Reset pulse -> State=0000 and Halt=0 asynchronously, before the next edge.
- Reset asserted mid-DECODE, off the clock edge -> all outputs 0 immediately. After release, the next edge gives State=0001.
